alu_fpga_harness: RTL and testbench

// Parametrised, clocked FPGA test harness for the ALU; successor to the combinational switch/key wrapper.

---
 rtl/alu_fpga_harness.sv | 165 ++++++++++++++++
 tb/tb_alu_fpga_harness.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_fpga_harness.sv
// rtl/alu_fpga_harness.sv - Clocked switch/key harness that drives and captures an external ALU
// Keys are synchronised and debounced; an FSM sequences operand load, execute and result capture.
module alu_fpga_harness #(
   parameter int DATA_W          = 32,
   parameter int OPND_W          = 16,
   parameter int OP_W            = 4,
   parameter int DIGITS          = 8,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int ALU_LAT         = 1
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [3:0]          KEY,
   input  logic [OPND_W+1:0]   SW,
   output logic [17:0]         LEDR,
   output logic [DIGITS*7-1:0] HEX,
   output logic [DATA_W-1:0]   alu_port_a,
   output logic [DATA_W-1:0]   alu_port_b,
   output logic [OP_W-1:0]     alu_op,
   input  logic [DATA_W-1:0]   alu_port_o,
   input  logic                alu_z,
   input  logic                alu_n,
   input  logic                alu_v
);
   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int WAIT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam int WORD_W = (DATA_W > DIGITS * 4) ? DATA_W : DIGITS * 4;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CAPT} state_t;

   logic [3:0]        key_s1_q, key_s2_q;
   logic [OPND_W+1:0] sw_s1_q, sw_s2_q;
   logic [CNT_W-1:0]  cnt_q [4];
   logic [CNT_W-1:0]  cnt_d [4];
   logic [3:0]        acc_q, acc_d;
   logic [3:0]        press_q, press_d;

   state_t            state_q;
   logic [WAIT_W-1:0] wait_q;
   logic [DATA_W-1:0] a_q, b_q, res_q;
   logic [OP_W-1:0]   op_q;
   logic [2:0]        flags_q;
   logic              busy_q;
   logic [9:0]        exec_cnt_q;
   logic [WORD_W-1:0] word;

   // Keys idle high, so the synchronisers and accepted levels reset to 1 to avoid a phantom press.
   always_ff @(posedge CLK) begin
      if (RST) begin
         key_s1_q <= '1;
         key_s2_q <= '1;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         acc_q    <= '1;
         press_q  <= '0;
         for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      end else begin
         key_s1_q <= KEY;
         key_s2_q <= key_s1_q;
         sw_s1_q  <= SW;
         sw_s2_q  <= sw_s1_q;
         acc_q    <= acc_d;
         press_q  <= press_d;
         for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
      end
   end

   always_comb begin
      acc_d   = acc_q;
      press_d = '0;
      for (int k = 0; k < 4; k++) begin
         cnt_d[k] = '0;
         if (key_s2_q[k] != acc_q[k]) begin
            if (cnt_q[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               acc_d[k]   = key_s2_q[k];
               press_d[k] = ~key_s2_q[k];
            end else begin
               cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         wait_q     <= '0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         res_q      <= '0;
         flags_q    <= '0;
         busy_q     <= 1'b0;
         exec_cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (press_q[3]) begin
                  state_q <= S_EXEC;
                  wait_q  <= WAIT_W'(ALU_LAT - 1);
                  busy_q  <= 1'b1;
               end else if (press_q[2]) begin
                  op_q <= sw_s2_q[OP_W-1:0];
               end else if (press_q[1]) begin
                  b_q <= DATA_W'(sw_s2_q[OPND_W-1:0]);
               end else if (press_q[0]) begin
                  a_q <= DATA_W'(sw_s2_q[OPND_W-1:0]);
               end
            end
            S_EXEC: begin
               if (wait_q == '0) state_q <= S_CAPT;
               else              wait_q  <= wait_q - WAIT_W'(1);
            end
            S_CAPT: begin
               res_q      <= alu_port_o;
               flags_q    <= {alu_z, alu_n, alu_v};
               exec_cnt_q <= exec_cnt_q + 10'd1;
               busy_q     <= 1'b0;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign alu_port_a = a_q;
   assign alu_port_b = b_q;
   assign alu_op     = op_q;
   assign LEDR       = {exec_cnt_q, 4'(op_q), busy_q, flags_q};

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      case (nib)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b0100111;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      case (sw_s2_q[OPND_W+1:OPND_W])
         2'b00:   word = WORD_W'(res_q);
         2'b01:   word = WORD_W'(a_q);
         2'b10:   word = WORD_W'(b_q);
         default: word = WORD_W'({flags_q, op_q});
      endcase
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign HEX[7*i +: 7] = hex7(word[4*i +: 4]);
   end

endmodule

// File: tb/tb_alu_fpga_harness.sv
// tb/tb_alu_fpga_harness.sv - Vector-table and scoreboard bench for alu_fpga_harness
// dut1 runs with ALU_LAT=1, dut4 with ALU_LAT=4; both share RST and SW.
module tb_alu_fpga_harness;
   localparam int DATA_W = 32;
   localparam int OPND_W = 16;
   localparam int OP_W   = 4;
   localparam int DIGITS = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic [3:0]          key1, key4;
   logic [OPND_W+1:0]   sw;
   logic [17:0]         ledr1, ledr4;
   logic [DIGITS*7-1:0] hex1, hex4;
   logic [DATA_W-1:0]   a1, b1, o1, a4, b4, o4;
   logic [OP_W-1:0]     op1, op4;
   logic                z1, n1, v1, z4, n4, v4;

   function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
      logic [31:0] r;
      logic        v;
      v = 1'b0;
      case (op)
         4'h0: r = a + b;
         4'h1: r = a & b;
         4'h2: r = a | b;
         4'h3: r = a - b;
         4'h4: r = a ^ b;
         4'hA: begin r = (a == b) ? 32'd0 : 32'd1; v = (a == b); end
         default: r = a;
      endcase
      return {r, (r == 32'd0), r[31], v};
   endfunction

   assign {o1, z1, n1, v1} = alu_model(a1, b1, op1);
   assign {o4, z4, n4, v4} = alu_model(a4, b4, op4);

   alu_fpga_harness #(.DATA_W(DATA_W), .OPND_W(OPND_W), .OP_W(OP_W), .DIGITS(DIGITS),
                      .DEBOUNCE_CYCLES(4), .ALU_LAT(1)) dut1 (
      .CLK(clk), .RST(rst), .KEY(key1), .SW(sw), .LEDR(ledr1), .HEX(hex1),
      .alu_port_a(a1), .alu_port_b(b1), .alu_op(op1), .alu_port_o(o1),
      .alu_z(z1), .alu_n(n1), .alu_v(v1));

   alu_fpga_harness #(.DATA_W(DATA_W), .OPND_W(OPND_W), .OP_W(OP_W), .DIGITS(DIGITS),
                      .DEBOUNCE_CYCLES(4), .ALU_LAT(4)) dut4 (
      .CLK(clk), .RST(rst), .KEY(key4), .SW(sw), .LEDR(ledr4), .HEX(hex4),
      .alu_port_a(a4), .alu_port_b(b4), .alu_op(op4), .alu_port_o(o4),
      .alu_z(z4), .alu_n(n4), .alu_v(v4));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] seg(input logic [3:0] nib);
      logic [6:0] t [16];
      t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
            7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110};
      return t[nib];
   endfunction

   function automatic logic [55:0] exp_hex(input logic [31:0] w);
      logic [55:0] h;
      for (int i = 0; i < 8; i++) h[7*i +: 7] = seg(w[4*i +: 4]);
      return h;
   endfunction

   typedef struct packed {
      logic [31:0] res;
      logic [2:0]  flg;
   } exp_t;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  op;
      logic [31:0] res;
      logic [2:0]  flg;
   } vec_t;

   exp_t sb[$];

   // Captures from dut1: each busy fall pops one expected result.
   initial begin : monitor
      bit   prev_busy;
      int   busy_len;
      exp_t e;
      prev_busy = 1'b0;
      busy_len  = 0;
      forever begin
         @(negedge clk);
         if (ledr1[3] === 1'b1) begin
            busy_len++;
         end else if (prev_busy) begin
            check("busy_len", 64'(busy_len), 64'd2);
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_capture actual=capture expected=none");
            end else begin
               e = sb.pop_front();
               check("cap_flags", 64'(ledr1[2:0]), 64'(e.flg));
               check("cap_hex", 64'(hex1), 64'(exp_hex(e.res)));
            end
            busy_len = 0;
         end
         prev_busy = (ledr1[3] === 1'b1);
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press1(input int k, input int hold);
      key1[k] = 1'b0;
      cycles(hold);
      key1[k] = 1'b1;
      cycles(10);
   endtask

   task automatic press4(input int k, input int hold);
      key4[k] = 1'b0;
      cycles(hold);
      key4[k] = 1'b1;
      cycles(10);
   endtask

   task automatic load1(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
      sw = {2'b00, a};
      cycles(1);
      press1(0, 6);
      sw = {2'b00, b};
      press1(1, 6);
      sw = {2'b00, 12'h000, op};
      press1(2, 6);
   endtask

   task automatic exec1(input logic [31:0] res, input logic [2:0] flg);
      exp_t e;
      e.res = res;
      e.flg = flg;
      sb.push_back(e);
      press1(3, 6);
   endtask

   vec_t vecs [11];

   initial begin : main
      bit seen;
      vecs[0]  = '{16'h0005, 16'h0007, 4'h3, 32'hFFFFFFFE, 3'b010};
      vecs[1]  = '{16'h1234, 16'h4321, 4'h0, 32'h00005555, 3'b000};
      vecs[2]  = '{16'hFFFF, 16'hFFFF, 4'h0, 32'h0001FFFE, 3'b000};
      vecs[3]  = '{16'h00F0, 16'h0FF0, 4'h1, 32'h000000F0, 3'b000};
      vecs[4]  = '{16'h00F0, 16'h0F0F, 4'h1, 32'h00000000, 3'b100};
      vecs[5]  = '{16'hA5A5, 16'h5A5A, 4'h2, 32'h0000FFFF, 3'b000};
      vecs[6]  = '{16'h1234, 16'h1234, 4'h3, 32'h00000000, 3'b100};
      vecs[7]  = '{16'hFFFF, 16'h00FF, 4'h4, 32'h0000FF00, 3'b000};
      vecs[8]  = '{16'h0000, 16'h0001, 4'h3, 32'hFFFFFFFF, 3'b010};
      vecs[9]  = '{16'h0042, 16'h0042, 4'hA, 32'h00000000, 3'b101};
      vecs[10] = '{16'h0042, 16'h0043, 4'hA, 32'h00000001, 3'b000};

      rst  = 1'b1;
      key1 = 4'hF;
      key4 = 4'hF;
      sw   = '0;
      cycles(2);
      rst = 1'b0;
      cycles(1);
      check("rst_ledr1", 64'(ledr1), 64'd0);
      check("rst_hex1", 64'(hex1), 64'({8{7'h40}}));
      check("rst_a1", 64'(a1), 64'd0);
      check("rst_b1", 64'(b1), 64'd0);
      check("rst_op1", 64'(op1), 64'd0);
      check("rst_ledr4", 64'(ledr4), 64'd0);
      check("rst_hex4", 64'(hex4), 64'({8{7'h40}}));

      sw = 18'h01234;
      cycles(2);
      key1[0] = 1'b0;
      cycles(2);
      key1[0] = 1'b1;
      cycles(10);
      check("glitch_a", 64'(a1), 64'd0);
      key1[0] = 1'b0;
      cycles(4);
      check("debounce_early_a", 64'(a1), 64'd0);
      cycles(8);
      check("debounce_a", 64'(a1), 64'h00001234);
      sw = 18'h05555;
      cycles(10);
      key1[0] = 1'b1;
      cycles(12);
      check("hold_release_a", 64'(a1), 64'h00001234);

      for (int i = 0; i < 11; i++) begin
         load1(vecs[i].a, vecs[i].b, vecs[i].op);
         check("vec_a", 64'(a1), 64'({16'h0, vecs[i].a}));
         check("vec_b", 64'(b1), 64'({16'h0, vecs[i].b}));
         check("vec_op", 64'(op1), 64'(vecs[i].op));
         check("vec_led_op", 64'(ledr1[7:4]), 64'(vecs[i].op));
         exec1(vecs[i].res, vecs[i].flg);
         check("vec_count", 64'(ledr1[17:8]), 64'(i + 1));
      end

      sw = 18'h01111;
      cycles(2);
      press4(0, 6);
      sw = 18'h02222;
      press4(1, 6);
      check("pri_pre_a", 64'(a4), 64'h1111);
      check("pri_pre_b", 64'(b4), 64'h2222);
      sw = 18'h0BEEF;
      cycles(2);
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (c == 0) begin key4[3] = 1'b0; key4[0] = 1'b0; end
         if (c == 2) key4[1] = 1'b0;
         if (c == 6) begin key4[3] = 1'b1; key4[0] = 1'b1; end
         if (c == 8) key4[1] = 1'b1;
         @(negedge clk);
         if (ledr4[3] === 1'b1) seen = 1'b1;
      end
      check("pri_exec_seen", 64'(seen), 64'd1);
      check("pri_a_kept", 64'(a4), 64'h1111);
      check("pri_b_dropped", 64'(b4), 64'h2222);
      check("pri_count", 64'(ledr4[17:8]), 64'd1);
      check("pri_idle", 64'(ledr4[3]), 64'd0);
      check("pri_hex", 64'(hex4), 64'(exp_hex(32'h00003333)));

      seen = 1'b0;
      key4[3] = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (c == 6) key4[3] = 1'b1;
         @(negedge clk);
         if (ledr4[3] === 1'b1) seen = 1'b1;
      end
      key4 = 4'hF;
      check("midrst_exec_seen", 64'(seen), 64'd1);
      cycles(1);
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      check("midrst_ledr", 64'(ledr4), 64'd0);
      check("midrst_a", 64'(a4), 64'd0);
      check("midrst_hex", 64'(hex4), 64'({8{7'h40}}));
      cycles(12);
      check("midrst_no_capture", 64'(ledr4), 64'd0);

      load1(16'h0042, 16'h0042, 4'hA);
      for (int i = 0; i < 1024; i++) begin
         exec1(32'h0, 3'b101);
         if (i == 1022) check("count_1023", 64'(ledr1[17:8]), 64'd1023);
      end
      check("count_wrap", 64'(ledr1[17:8]), 64'd0);
      sw = {2'b11, 16'h0042};
      cycles(3);
      check("mode11_hex0", 64'(hex1[6:0]), 64'(7'b0001000));
      check("mode11_hex1", 64'(hex1[13:7]), 64'(7'b0010010));
      check("mode11_upper", 64'(hex1[55:14]), 64'({6{7'h40}}));
      sw = {2'b01, 16'h0042};
      cycles(3);
      check("mode01_hex", 64'(hex1), 64'(exp_hex(32'h00000042)));
      sw = {2'b10, 16'h0000};
      cycles(3);
      check("mode10_hex", 64'(hex1), 64'(exp_hex(32'h00000042)));

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
